// File: rtl/mul_share_scheduler.sv
// Shares one iterative shift-add multiplier between two execute lanes: round-robin
// grant, fixed WIDTH-cycle sequencing and a registered, tagged result.
module mul_share_scheduler #(
    parameter int WIDTH = 16,
    parameter int REG_W = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [REG_W-1:0] rd0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [REG_W-1:0] rd1,
    input  logic             flush,
    output logic             gnt0,
    output logic             gnt1,
    output logic             stall0,
    output logic             stall1,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [REG_W-1:0] result_rd,
    output logic             result_lane
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [REG_W-1:0] rd_q;
    logic             lane_q;
    logic             prio_q;
    logic             result_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [REG_W-1:0] result_rd_q;
    logic             result_lane_q;

    logic             grant_ok;
    logic             win1;
    logic [WIDTH-1:0] acc_d;
    logic             last_iter;

    // Grants are gated by reset_n so the pipeline sees no grant or stall while
    // the block is held in reset, even with requests pending.
    always_comb begin
        grant_ok  = reset_n && (state_q == IDLE) && !flush && (req0 || req1);
        win1      = req1 && (!req0 || prio_q);
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    assign gnt0         = grant_ok && !win1;
    assign gnt1         = grant_ok && win1;
    assign stall0       = reset_n && req0 && !gnt0;
    assign stall1       = reset_n && req1 && !gnt1;
    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_rd    = result_rd_q;
    assign result_lane  = result_lane_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            rd_q           <= '0;
            lane_q         <= 1'b0;
            prio_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_rd_q    <= '0;
            result_lane_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_ok) begin
                        mcand_q  <= win1 ? a1 : a0;
                        mplier_q <= win1 ? b1 : b0;
                        rd_q     <= win1 ? rd1 : rd0;
                        lane_q   <= win1;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        prio_q   <= !win1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        // The final partial product is folded in on the way to DONE.
                        if (last_iter) begin
                            result_q       <= acc_d;
                            result_rd_q    <= rd_q;
                            result_lane_q  <= lane_q;
                            result_valid_q <= 1'b1;
                            state_q        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Directed bench for mul_share_scheduler: a cycle-level behavioural model checked every
// cycle, plus hand-computed latencies and products for each scenario.
module tb_mul_share_scheduler;

    localparam int WIDTH = 16;
    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             req0 = 1'b0;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic [REG_W-1:0] rd0 = '0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic [REG_W-1:0] rd1 = '0;
    logic             flush = 1'b0;
    logic             gnt0;
    logic             gnt1;
    logic             stall0;
    logic             stall1;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [REG_W-1:0] result_rd;
    logic             result_lane;

    mul_share_scheduler #(.WIDTH(WIDTH), .REG_W(REG_W), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .a0(a0), .b0(b0), .rd0(rd0),
        .req1(req1), .a1(a1), .b1(b1), .rd1(rd1),
        .flush(flush),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
        .busy(busy), .result_valid(result_valid), .result(result),
        .result_rd(result_rd), .result_lane(result_lane)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: remaining busy cycles, who has priority, pending and delivered results.
    int               mBusy = 0;
    bit               mPrio = 1'b0;
    bit               mValid = 1'b0;
    logic [WIDTH-1:0] mRes = '0;
    logic [REG_W-1:0] mRd = '0;
    bit               mLane = 1'b0;
    logic [WIDTH-1:0] mPendRes = '0;
    logic [REG_W-1:0] mPendRd = '0;
    bit               mPendLane = 1'b0;
    bit               eBusy, eCan, eWin1, eG0, eG1;
    longint           prod;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                                 input logic [REG_W-1:0] d0, input logic r1, input logic [WIDTH-1:0] x1,
                                 input logic [WIDTH-1:0] y1, input logic [REG_W-1:0] d1, input logic fl);
        req0 = r0; a0 = x0; b0 = y0; rd0 = d0;
        req1 = r1; a1 = x1; b1 = y1; rd1 = d1;
        flush = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of the cycle after a grant; n is the offset from the grant cycle.
    task automatic waitResult(output int n);
        n = 1;
        @(negedge clk);
        while (!result_valid && n < 40) begin
            nextCycle();
            @(negedge clk);
            n++;
        end
        if (!result_valid) checkOutput("result timeout", 0, 1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    // Every cycle: compare all outputs with the model, then advance the model using
    // the inputs that the DUT will see at the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mBusy = 0; mPrio = 1'b0; mValid = 1'b0;
            mRes = '0; mRd = '0; mLane = 1'b0;
            checkOutput("rst busy", busy, 0);
            checkOutput("rst gnt0", gnt0, 0);
            checkOutput("rst gnt1", gnt1, 0);
            checkOutput("rst stall0", stall0, 0);
            checkOutput("rst stall1", stall1, 0);
            checkOutput("rst result_valid", result_valid, 0);
            checkOutput("rst result", result, 0);
            checkOutput("rst result_rd", result_rd, 0);
            checkOutput("rst result_lane", result_lane, 0);
        end else begin
            eBusy = (mBusy > 0);
            eCan  = !eBusy && !flush && (req0 || req1);
            if (req0 && req1) eWin1 = mPrio;
            else              eWin1 = req1;
            eG0 = eCan && !eWin1;
            eG1 = eCan && eWin1;
            checkOutput("cmp busy", busy, eBusy);
            checkOutput("cmp gnt0", gnt0, eG0);
            checkOutput("cmp gnt1", gnt1, eG1);
            checkOutput("cmp stall0", stall0, req0 && !eG0);
            checkOutput("cmp stall1", stall1, req1 && !eG1);
            checkOutput("cmp result_valid", result_valid, mValid);
            checkOutput("cmp result", result, mRes);
            checkOutput("cmp result_rd", result_rd, mRd);
            checkOutput("cmp result_lane", result_lane, mLane);
            if (eBusy) begin
                if (flush) begin
                    mBusy  = 0;
                    mValid = 1'b0;
                end else begin
                    mValid = (mBusy == 2);
                    if (mValid) begin
                        mRes = mPendRes; mRd = mPendRd; mLane = mPendLane;
                    end
                    mBusy--;
                end
            end else begin
                mValid = 1'b0;
                if (eCan) begin
                    if (eWin1) prod = longint'(a1) * longint'(b1);
                    else       prod = longint'(a0) * longint'(b0);
                    mPendRes  = WIDTH'(prod % 65536);
                    mPendRd   = eWin1 ? rd1 : rd0;
                    mPendLane = eWin1;
                    mPrio     = !eWin1;
                    mBusy     = WIDTH + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, nFails=%0d", nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("init busy", busy, 0);
        checkOutput("init result_valid", result_valid, 0);
        checkOutput("init result", result, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Single lane 0 request; operands changed after grant must be ignored
        applyStimulus(1, 7, 9, 3, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 gnt0", gnt0, 1);
        checkOutput("t1 stall0", stall0, 0);
        nextCycle();
        applyStimulus(0, 1000, 1000, 9, 0, 0, 0, 0, 0);
        waitResult(n);
        checkOutput("t1 latency", n, 17);
        checkOutput("t1 result", result, 63);
        checkOutput("t1 rd", result_rd, 3);
        checkOutput("t1 lane", result_lane, 0);

        // Both lanes request after reset: lane 0 first, lane 1 waits stalled
        doReset();
        applyStimulus(1, 5, 6, 1, 1, 300, 300, 2, 0);
        @(negedge clk);
        checkOutput("t2 gnt0", gnt0, 1);
        checkOutput("t2 gnt1", gnt1, 0);
        checkOutput("t2 stall1", stall1, 1);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t2 latency0", n, 17);
        checkOutput("t2 result0", result, 30);
        checkOutput("t2 rd0", result_rd, 1);
        checkOutput("t2 lane0", result_lane, 0);
        checkOutput("t2 stall1 at 17", stall1, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("t2 gnt1 at 18", gnt1, 1);
        checkOutput("t2 stall1 at 18", stall1, 0);
        nextCycle();
        req1 = 1'b0;
        waitResult(n);
        checkOutput("t2 latency1", n, 17);
        checkOutput("t2 result1", result, 24464);
        checkOutput("t2 rd1", result_rd, 2);
        checkOutput("t2 lane1", result_lane, 1);

        // Round robin: priority back at lane 0, then at lane 1
        nextCycle();
        applyStimulus(1, 3, 4, 4, 1, 11, 13, 5, 0);
        @(negedge clk);
        checkOutput("t3 gnt0 first", gnt0, 1);
        checkOutput("t3 gnt1 first", gnt1, 0);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t3 latency a", n, 17);
        checkOutput("t3 result a", result, 12);
        nextCycle();
        applyStimulus(1, 20, 30, 6, 1, 11, 13, 5, 0);
        @(negedge clk);
        checkOutput("t3 gnt1 second", gnt1, 1);
        checkOutput("t3 gnt0 second", gnt0, 0);
        checkOutput("t3 stall0", stall0, 1);
        nextCycle();
        req1 = 1'b0;
        waitResult(n);
        checkOutput("t3 result b", result, 143);
        checkOutput("t3 lane b", result_lane, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("t3 gnt0 third", gnt0, 1);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t3 result c", result, 600);
        checkOutput("t3 rd c", result_rd, 6);

        // Extreme operands: truncation and zero
        nextCycle();
        applyStimulus(1, 16'hFFFF, 16'hFFFF, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 gnt0 a", gnt0, 1);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t4 latency a", n, 17);
        checkOutput("t4 result a", result, 1);
        nextCycle();
        applyStimulus(1, 16'h0000, 16'h1234, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 gnt0 b", gnt0, 1);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t4 latency b", n, 17);
        checkOutput("t4 result b", result, 0);
        checkOutput("t4 rd b", result_rd, 8);

        // Flush in RUN aborts lane 0; lane 1 is served right after
        nextCycle();
        applyStimulus(1, 100, 200, 12, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5 gnt0", gnt0, 1);
        nextCycle();
        applyStimulus(0, 100, 200, 12, 1, 21, 2, 13, 0);
        repeat (7) nextCycle();
        flush = 1'b1;
        @(negedge clk);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("t5 busy at 9", busy, 0);
        checkOutput("t5 gnt1 at 9", gnt1, 1);
        checkOutput("t5 no valid", result_valid, 0);
        checkOutput("t5 rd held", result_rd, 8);
        nextCycle();
        req1 = 1'b0;
        waitResult(n);
        checkOutput("t5 latency", n, 17);
        checkOutput("t5 result", result, 42);
        checkOutput("t5 rd", result_rd, 13);
        checkOutput("t5 lane", result_lane, 1);

        // Flush in IDLE blocks the grant
        nextCycle();
        applyStimulus(1, 1234, 5, 10, 0, 3, 3, 11, 1);
        @(negedge clk);
        checkOutput("idle flush gnt0", gnt0, 0);
        checkOutput("idle flush stall0", stall0, 1);

        // Asynchronous reset in the middle of RUN
        nextCycle();
        applyStimulus(1, 1234, 5, 10, 1, 3, 3, 11, 0);
        @(negedge clk);
        checkOutput("t6 gnt0", gnt0, 1);
        repeat (10) nextCycle();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6 rst busy", busy, 0);
        checkOutput("t6 rst valid", result_valid, 0);
        checkOutput("t6 rst result", result, 0);
        checkOutput("t6 rst gnt0", gnt0, 0);
        checkOutput("t6 rst gnt1", gnt1, 0);
        checkOutput("t6 rst stall0", stall0, 0);
        checkOutput("t6 rst stall1", stall1, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t6 post gnt0", gnt0, 1);
        checkOutput("t6 post gnt1", gnt1, 0);
        nextCycle();
        req0 = 1'b0;
        waitResult(n);
        checkOutput("t6 latency", n, 17);
        checkOutput("t6 result", result, 6170);
        checkOutput("t6 rd", result_rd, 10);
        nextCycle();
        @(negedge clk);
        checkOutput("t6 gnt1", gnt1, 1);
        nextCycle();
        req1 = 1'b0;
        waitResult(n);
        checkOutput("t6 result lane1", result, 9);
        checkOutput("t6 lane1", result_lane, 1);
        repeat (3) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mul_share_scheduler.md
Name: mul_share_scheduler

Overview:
- Shares one iterative 16-bit shift-add multiplier between the two execute lanes of the superscalar pipeline.
- Replaces each lane's single-cycle ALU multiply path (funct 100001) with a shared, sequenced resource.
- Arbitrates round-robin between lanes, sequences the multiply over WIDTH cycles, and returns a tagged result.
- Drives per-lane stall signals back to the pipeline control.

Parameters:
WIDTH, 16, operand and result width; also the number of iteration cycles
REG_W, 5, destination register tag width
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req0  input  1  lane 0 multiply request; held high until gnt0
a0  input  WIDTH  lane 0 operand A (post-forwarding)
b0  input  WIDTH  lane 0 operand B (post-forwarding)
rd0  input  REG_W  lane 0 destination register
req1, a1, b1, rd1  input  1/WIDTH/WIDTH/REG_W  lane 1 equivalents
flush  input  1  synchronous abort of the in-flight operation
gnt0  output  1  lane 0 accepted; combinational, one-cycle pulse
gnt1  output  1  lane 1 accepted
stall0  output  1  req0 & ~gnt0
stall1  output  1  req1 & ~gnt1
busy  output  1  state != IDLE
result_valid  output  1  registered, one-cycle pulse
result  output  WIDTH  low WIDTH bits of A*B (unsigned, truncated)
result_rd  output  REG_W  destination tag of the completed operation
result_lane  output  1  lane that issued the completed operation

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, counter=0, accumulator/operand registers=0, result_valid=0, result=0, result_rd=0, result_lane=0, priority pointer=lane 0. Outputs reach these values without waiting for a clock edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - If no req, or flush=1: stay in IDLE with no grant.
  - Otherwise, select one requester. A single requester wins. With two requesters, the lane named by the priority pointer wins.
  - Assert the winner's gnt in the same cycle. At the clock edge, latch A, B, rd and lane, clear the accumulator, set counter=0, go to RUN, and point priority at the other lane.
- RUN, each cycle:
  - If multiplier bit0=1, acc <= acc + multiplicand (mod 2^WIDTH).
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - When counter==WIDTH-1, load result/result_rd/result_lane from the final accumulator value and go to DONE.
  - No early termination; latency is fixed.
- DONE: result_valid=1 for exactly this cycle, then go to IDLE. No grant is issued in DONE.
- Timing: grant at cycle T, RUN occupies T+1..T+WIDTH, result_valid at T+WIDTH+1. The earliest next grant is T+WIDTH+2.
- result/result_rd/result_lane hold their values after the pulse until the next completion.
- gnt0 and gnt1 are mutually exclusive. No grant is issued while busy=1.
- A lane whose req drops before grant is simply not served; no state is kept for it.
- flush in RUN or DONE: next state is IDLE. Suppress result_valid if not already asserted; result registers are not updated. A flush arriving in DONE does not cancel that cycle's already-asserted pulse.
- flush in IDLE: blocks grants that cycle.
- rd=0 is executed normally and delivered with result_rd=0; write suppression is downstream.
- Operand inputs are sampled only at grant, so changes after grant have no effect.

Test Plan:
1. After reset, lane 0 requests a0=7, b0=9, rd0=3 at cycle 0. Expect: gnt0=1 at cycle 0; busy=1 for cycles 1..17; result_valid only at cycle 17 with result=63, result_rd=3, result_lane=0; stall0=0 throughout.
2. Both lanes request at cycle 0: lane 0 (5*6, rd0=1) and lane 1 (a1=300, b1=300, rd1=2). Expect:
   - gnt0 at 0; stall1=1 for cycles 0..17.
   - gnt1 at 18.
   - Results: 30/rd1/lane0 at cycle 17, then 24464 (90000 mod 65536)/rd2/lane1 at cycle 35.
3. Round-robin check: after test 2's lane 1 completes, both lanes request simultaneously. Expect lane 0 granted first; then repeat with priority at lane 1 and expect gnt1 first.
4. Lane 0 granted 0xFFFF*0xFFFF; a second run does 0x0000*0x1234. Expect result 0x0001, then 0x0000, each with valid at grant+17.
5. Lane 0 granted at 0, flush=1 at cycle 8, req1 held high. Expect:
   - No result_valid for lane 0; busy=0 at cycle 9.
   - gnt1 at cycle 9; lane 1 result at cycle 26.
   - result registers unchanged until cycle 26.
6. reset_n pulsed low mid-cycle at cycle 10 of a RUN. Expect busy, result_valid, result, gnt* and stall* = 0 immediately. After release with both lanes requesting, lane 0 is granted first.
